// File: rtl/oam_dma.sv
// oam_dma: copies XFER_LEN bytes from page {src,00} of the system bus into OAM.
//
// A CPU write to FF46 (sampled on the t_cycle==3 edge) latches the source page
// and starts a transfer: one START M-cycle, then XFER_LEN XFER M-cycles. Each
// XFER M-cycle reads {eff_src, idx} over the bus. The byte is written into OAM
// at the t_cycle==3 edge that closes that M-cycle.
//
// Bus ownership: in IDLE and START the CPU owns the system bus, and its
// signals pass straight through. The FF46 register is the exception: it is
// never forwarded. In XFER the DMA owns the bus. CPU reads then return 8'hFF
// and CPU writes are dropped, except for accesses to FF46.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   t_cycle[1:0]         T-cycle phase, M-cycle boundary at 3
//   cpu_*                CPU-side access (addr, enable, write, wdata, rdata)
//   bus_*                system bus toward memory
//   oam_*                OAM write port
//   dma_active           high in START or XFER
//   dbg_state_o[1:0]     current FSM state, for debug and checkers
module oam_dma #(
  parameter int XFER_LEN = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write,
  output logic        dma_active,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;

  logic       m_edge;
  logic       is_ff46;
  logic       ff46_wr;
  logic [7:0] eff_src;

  assign m_edge  = (t_cycle == 2'd3);
  assign is_ff46 = (cpu_addr == 16'hFF46);
  assign ff46_wr = cpu_enable & cpu_write & is_ff46 & m_edge;

  // Pages E0-FF are echo RAM. Fold them back onto C0-DF.
  assign eff_src = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
    end
  end

  // A FF46 write restarts the transfer from any state. It wins over the
  // advance or completion that would otherwise happen at the same edge.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    if (ff46_wr) begin
      src_d   = cpu_wdata;
      idx_d   = 8'h00;
      state_d = START;
    end else if (m_edge) begin
      case (state_q)
        START: state_d = XFER;
        XFER: begin
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + 8'h01;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bus_addr   = cpu_addr;
    bus_enable = cpu_enable & ~is_ff46;
    bus_write  = cpu_write;
    bus_wdata  = cpu_wdata;
    cpu_rdata  = is_ff46 ? src_q : bus_rdata;
    oam_addr   = 8'h00;
    oam_wdata  = 8'h00;
    oam_write  = 1'b0;
    if (state_q == XFER) begin
      bus_addr   = {eff_src, idx_q};
      bus_enable = 1'b1;
      bus_write  = 1'b0;
      bus_wdata  = 8'h00;
      cpu_rdata  = is_ff46 ? src_q : 8'hFF;
      oam_write  = m_edge;
      oam_addr   = idx_q;
      oam_wdata  = bus_rdata;
    end
  end

  assign dma_active  = (state_q == START) || (state_q == XFER);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;
  localparam int LEN = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_enable = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic        dma_active;
  logic [1:0]  dbg_state_o;

  oam_dma #(.XFER_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle),
    .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write(oam_write),
    .dma_active(dma_active), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The transfer is described as "bytes still to copy" plus a pending
  // one-M-cycle start delay. The byte being copied is LEN - remaining.
  bit         m_valid = 0;
  logic [7:0] m_src = 8'h00;
  bit         m_start = 0;
  int         m_rem = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_src   = 8'h00;
      m_start = 0;
      m_rem   = 0;
    end else if (t_cycle == 2'd3) begin
      if (cpu_enable && cpu_write && cpu_addr == 16'hFF46) begin
        m_src   = cpu_wdata;
        m_start = 1;
        m_rem   = LEN;
      end else if (m_start) begin
        m_start = 0;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int          oam_pulses = 0;
  int          act_mcycles = 0;
  bit          got_first = 0;
  logic [15:0] first_addr = 16'h0;
  logic [15:0] last_bus_addr = 16'h0;
  logic [7:0]  last_oam_addr = 8'h0;

  always @(negedge clk) begin
    if (m_valid) begin
      logic        xfer;
      logic [7:0]  idx;
      logic [7:0]  page;
      logic        ff;
      logic [15:0] e_addr;
      logic        e_en, e_wr, e_ow;
      logic [7:0]  e_wd, e_rd;
      xfer = !m_start && m_rem > 0;
      idx  = 8'(LEN - m_rem);
      page = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
      ff   = (cpu_addr == 16'hFF46);
      if (xfer) begin
        e_addr = {page, idx};
        e_en = 1'b1; e_wr = 1'b0; e_wd = 8'h00;
        e_rd = ff ? m_src : 8'hFF;
        e_ow = (t_cycle == 2'd3);
      end else begin
        e_addr = cpu_addr;
        e_en = cpu_enable && !ff; e_wr = cpu_write; e_wd = cpu_wdata;
        e_rd = ff ? m_src : bus_rdata;
        e_ow = 1'b0;
      end
      chk("bus_addr", 32'(bus_addr), 32'(e_addr));
      chk("bus_enable", 32'(bus_enable), 32'(e_en));
      chk("bus_write", 32'(bus_write), 32'(e_wr));
      chk("bus_wdata", 32'(bus_wdata), 32'(e_wd));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
      chk("oam_write", 32'(oam_write), 32'(e_ow));
      chk("dma_active", 32'(dma_active), 32'(m_start || m_rem > 0));
      if (e_ow) begin
        chk("oam_addr", 32'(oam_addr), 32'(idx));
        chk("oam_wdata", 32'(oam_wdata), 32'(bus_rdata));
      end
    end
    if (oam_write) begin
      oam_pulses++;
      last_oam_addr = oam_addr;
      last_bus_addr = bus_addr;
      if (!got_first) begin
        got_first  = 1;
        first_addr = bus_addr;
      end
    end
    if (dma_active && t_cycle == 2'd3) act_mcycles++;
  end

  // ---------------- driver tasks ----------------
  bit bg_mode = 0;

  task automatic drive_bg();
    if (bg_mode) begin
      int r;
      r = $urandom_range(0, 255);
      cpu_enable = 1'($urandom_range(0, 1));
      cpu_write  = 1'($urandom_range(0, 1));
      cpu_wdata  = 8'($urandom);
      if (r == 0)      cpu_addr = 16'hFF46;
      else if (r < 40) cpu_addr = 16'h0150;
      else if (r < 80) cpu_addr = 16'hC000;
      else begin
        cpu_addr = 16'($urandom);
        if (cpu_addr == 16'hFF46) cpu_addr = 16'hFF47;
      end
    end else begin
      cpu_enable = 1'b0;
      cpu_write  = 1'b0;
      cpu_addr   = 16'h0000;
      cpu_wdata  = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t_cycle   = t_cycle + 2'd1;
    bus_rdata = 8'($urandom);
    drive_bg();
  endtask

  task automatic clear_mon();
    oam_pulses  = 0;
    act_mcycles = 0;
    got_first   = 0;
  endtask

  // Present a FF46 write in the next t_cycle==3 slot, let the edge take it.
  task automatic ff46_write(input logic [7:0] v);
    int n;
    n = 0;
    while (t_cycle != 2'd3 && n < 8) begin
      tick();
      n++;
    end
    cpu_enable = 1'b1;
    cpu_write  = 1'b1;
    cpu_addr   = 16'hFF46;
    cpu_wdata  = v;
    tick();
    clear_mon();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (dma_active && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 32'(dma_active), 32'd0);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (oam_pulses < target && n < budget) begin
      tick();
      n++;
    end
    chk("wait_pulses_timeout", 32'(oam_pulses), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    tick();

    // After reset: FF46 reads 00, nothing active, no OAM write.
    cpu_enable = 1'b1; cpu_write = 1'b0; cpu_addr = 16'hFF46;
    @(negedge clk);
    chk("rst_ff46_read", 32'(cpu_rdata), 32'h00);
    chk("rst_dma_active", 32'(dma_active), 32'd0);
    chk("rst_oam_write", 32'(oam_write), 32'd0);
    chk("rst_ff46_not_fwd", 32'(bus_enable), 32'd0);

    // Full transfer from C1, with a CPU read and a CPU write while it runs.
    ff46_write(8'hC1);
    begin
      int n;
      bit did;
      n = 0;
      did = 0;
      while (dma_active && n < 2000) begin
        tick();
        n++;
        if (!did && oam_pulses == 20) begin
          cpu_enable = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0150;
          @(negedge clk);
          chk("xfer_read_ff", 32'(cpu_rdata), 32'hFF);
          chk("xfer_read_page", 32'(bus_addr[15:8]), 32'hC1);
          tick();
          cpu_enable = 1'b1; cpu_write = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'h55;
          @(negedge clk);
          chk("xfer_write_dropped", 32'(bus_write), 32'd0);
          did = 1;
        end
      end
      chk("c1_timeout", 32'(dma_active), 32'd0);
    end
    chk("c1_pulses", 32'(oam_pulses), 32'd160);
    chk("c1_active_mcycles", 32'(act_mcycles), 32'd161);
    chk("c1_first_addr", 32'(first_addr), 32'hC100);
    chk("c1_last_addr", 32'(last_bus_addr), 32'hC19F);
    chk("c1_last_oam", 32'(last_oam_addr), 32'h9F);

    // Echo page F3 reads from D3.
    ff46_write(8'hF3);
    wait_idle(2000);
    chk("f3_first_addr", 32'(first_addr), 32'hD300);
    chk("f3_last_addr", 32'(last_bus_addr), 32'hD39F);
    chk("f3_pulses", 32'(oam_pulses), 32'd160);

    // Restart at idx 40 with page 80.
    ff46_write(8'h12);
    wait_pulses(8'h40, 2000);
    ff46_write(8'h80);
    wait_idle(2000);
    chk("rs_first_addr", 32'(first_addr), 32'h8000);
    chk("rs_pulses", 32'(oam_pulses), 32'd160);
    chk("rs_active_mcycles", 32'(act_mcycles), 32'd161);
    chk("rs_last_addr", 32'(last_bus_addr), 32'h809F);

    // Reset mid-transfer at idx 50.
    ff46_write(8'hC5);
    wait_pulses(8'h50, 2000);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_active", 32'(dma_active), 32'd0);
    chk("rst_mid_oam", 32'(oam_write), 32'd0);
    tick();
    reset = 1'b0;
    clear_mon();
    repeat (100) tick();
    chk("rst_mid_no_oam", 32'(oam_pulses), 32'd0);
    chk("rst_mid_idle", 32'(dma_active), 32'd0);

    // Random traffic, including rare FF46 writes and rare resets.
    bg_mode = 1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      reset = ($urandom_range(0, 1999) == 0);
    end
    reset = 1'b0;
    bg_mode = 0;
    tick();
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter XFER_LEN, default 160, meaning the number of bytes copied per transfer.
REQ-002 SHALL have port clk  in  1  system clock (4 MHz T-cycle clock).
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port t_cycle  in  2  CPU T-cycle phase; the M-cycle boundary is at t_cycle==3.
REQ-005 SHALL have port cpu_addr  in  16  CPU bus address.
REQ-006 SHALL have port cpu_enable  in  1  CPU bus access enable.
REQ-007 SHALL have port cpu_write  in  1  CPU bus write enable.
REQ-008 SHALL have port cpu_wdata  in  8  CPU write data.
REQ-009 SHALL have port cpu_rdata  out  8  read data returned to the CPU.
REQ-010 SHALL have ports bus_addr (out, 16), bus_enable (out, 1), bus_write (out, 1), bus_wdata (out, 8), bus_rdata (in, 8), forming the system bus toward memory.
REQ-011 SHALL have ports oam_addr (out, 8), oam_wdata (out, 8), oam_write (out, 1), forming the OAM write port.
REQ-012 SHALL have port dma_active  out  1  high while a transfer is pending or running.

Function
REQ-013 SHALL implement states IDLE, START, XFER, a source register src[7:0] and an index idx[7:0].
REQ-014 SHALL treat a CPU access as a "FF46 write" when cpu_enable, cpu_write and cpu_addr==16'hFF46 are all high at a clk edge with t_cycle==3.
REQ-015 SHALL, on a FF46 write in any state, load src<=cpu_wdata, set idx<=0 and enter START.
REQ-016 SHALL leave START for XFER at the next t_cycle==3 edge, giving exactly one M-cycle of start delay.
REQ-017 SHALL, in XFER, drive bus_addr={eff_src, idx}, bus_enable=1, bus_write=0, bus_wdata=0 for the whole M-cycle.
REQ-018 SHALL compute eff_src = src-8'h20 when src>=8'hE0, else src, so that echo RAM maps to C000-DFFF.
REQ-019 SHALL, in XFER, drive oam_write=1 only during t_cycle==3, with oam_addr=idx and oam_wdata=bus_rdata; oam_write SHALL be 0 at all other times.
REQ-020 SHALL, at each t_cycle==3 edge in XFER without a FF46 write: if idx==XFER_LEN-1, enter IDLE; else idx<=idx+1.
REQ-021 SHALL therefore run exactly XFER_LEN XFER M-cycles, idx 0..XFER_LEN-1, with no wrap past XFER_LEN-1.
REQ-022 SHALL drive dma_active=1 exactly when the state is START or XFER.
REQ-023 SHALL, in IDLE and START, pass CPU signals combinationally to the bus (bus_addr=cpu_addr, bus_write=cpu_write, bus_wdata=cpu_wdata), with bus_enable=cpu_enable except bus_enable=0 for cpu_addr==FF46.
REQ-024 SHALL never forward a FF46 access to the bus; a CPU read of FF46 SHALL return src in every state.
REQ-025 SHALL, in XFER, return 8'hFF for CPU reads of any address other than FF46 and drop CPU writes other than FF46; the bus stays owned by the DMA.
REQ-026 SHALL otherwise return cpu_rdata=bus_rdata.
REQ-027 SHALL give a FF46 write priority over the XFER idx advance or completion at the same edge (restart wins).
REQ-028 SHALL change state, src and idx only on t_cycle==3 edges or on reset.

Reset
REQ-029 SHALL, on reset, set the state to IDLE, src=0 and idx=0; reset SHALL take priority over any FF46 write at the same edge.
REQ-030 SHALL, from the edge reset is sampled, drive dma_active=0 and oam_write=0, and pass the bus through per REQ-023.
REQ-031 SHALL abort a transfer when reset is applied mid-transfer, with no further OAM writes until the next FF46 write.

Verification
REQ-032 SHALL cover: reset, then CPU read of FF46 -> cpu_rdata=8'h00, dma_active=0, no oam_write.
REQ-033 SHALL cover: FF46 write of 8'hC1 -> one START M-cycle, then 160 M-cycles with bus_addr C100..C19F, oam_write pulses at oam_addr 00..9F carrying the bus_rdata of each cycle, dma_active high for 161 M-cycles, then IDLE.
REQ-034 SHALL cover: during XFER, CPU read of 0x0150 -> cpu_rdata=8'hFF with bus_addr unchanged; CPU write of C000 -> bus_write stays 0.
REQ-035 SHALL cover: FF46 write of 8'hF3 -> bus_addr sequence D300..D39F.
REQ-036 SHALL cover: FF46 write of 8'h80 at idx=8'h40 -> START for one M-cycle, then idx restarts at 0 from 8000, 160 full transfers follow.
REQ-037 SHALL cover: reset asserted at idx=8'h50 -> IDLE, dma_active=0 and no further oam_write.
